mem_access_unit: RTL

- Consumer end of the EX/MEM interface: turns the me_* bundle into a data-bus transaction and feeds the MEM/WB register.
- Generates store byte enables and replicated write data; extracts, sign- or zero-extends load data.
- Stalls the upstream pipeline while the bus is busy.
- Registers all writeback-stage outputs (MEM/WB).

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory access unit (master) and the data
// memory / bus fabric (slave).
`timescale 1ns/1ps
interface mem_access_unit_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: EX/MEM consumer, data-bus master and MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are suppressed on the bus and flagged with a misalign_err pulse.
//
// state | meaning
// IDLE  | no access outstanding; a zero-wait ack completes here
// WAIT  | access issued, waiting for dbus_ack; cnt counts waited cycles
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    me_RegWrite,
  input  logic                    me_MemWrite,
  input  logic [1:0]              me_WDsel,
  input  logic [1:0]              me_GPRSel,
  input  logic [2:0]              me_DMType,
  input  logic [31:0]             me_aluout,
  input  logic [31:0]             me_RD2,
  input  logic [4:0]              me_rd,
  input  logic [31:0]             me_PC,
  mem_access_unit_if.master       dbus,
  output logic                    mem_stall,
  output logic                    wb_RegWrite,
  output logic [1:0]              wb_WDsel,
  output logic [1:0]              wb_GPRSel,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_aluout,
  output logic [31:0]             wb_PC,
  output logic [31:0]             wb_mdata,
  output logic                    bus_err,
  output logic                    misalign_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wb_regwrite_q, wb_regwrite_d;
  logic [1:0]       wb_wdsel_q, wb_wdsel_d;
  logic [1:0]       wb_gprsel_q, wb_gprsel_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_aluout_q, wb_aluout_d;
  logic [31:0]      wb_pc_q, wb_pc_d;
  logic [31:0]      wb_mdata_q, wb_mdata_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_err_q, misalign_err_d;

  logic        is_byte, is_half, is_word, is_signed, is_load;
  logic        mem_req, misalign, mem_op, timeout;
  logic [1:0]  a_lo;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data;

  assign a_lo      = me_aluout[1:0];
  assign is_byte   = (me_DMType == 3'b011) || (me_DMType == 3'b100);
  assign is_half   = (me_DMType == 3'b001) || (me_DMType == 3'b010);
  assign is_word   = ~is_byte & ~is_half;
  assign is_signed = (me_DMType == 3'b000) || (me_DMType == 3'b001) ||
                     (me_DMType == 3'b011);
  assign is_load   = (me_WDsel == 2'b01);
  assign mem_req   = me_MemWrite | is_load;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_req & ((is_half & a_lo[0]) | (is_word & (a_lo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign mem_op  = mem_req & ~misalign;
  assign timeout = (state_q == WAIT) && (cnt_q == CNT_LAST) && !dbus.dbus_ack;
  assign mem_stall = mem_op & ~dbus.dbus_ack & ~timeout;

  // Bus request side: purely combinational from the EX/MEM bundle.
  always_comb begin
    dbus.dbus_req   = mem_op;
    dbus.dbus_we    = me_MemWrite;
    dbus.dbus_addr  = {me_aluout[31:2], 2'b00};
    dbus.dbus_be    = 4'b1111;
    dbus.dbus_wdata = me_RD2;
    if (is_byte) begin
      dbus.dbus_be    = 4'b0001 << a_lo;
      dbus.dbus_wdata = {4{me_RD2[7:0]}};
    end else if (is_half) begin
      dbus.dbus_be    = a_lo[1] ? 4'b1100 : 4'b0011;
      dbus.dbus_wdata = {2{me_RD2[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    rd_byte  = dbus.dbus_rdata[{a_lo, 3'b000} +: 8];
    rd_half  = dbus.dbus_rdata[{a_lo[1], 4'b0000} +: 16];
    ext_data = dbus.dbus_rdata;
    if (is_byte)
      ext_data = is_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
    else if (is_half)
      ext_data = is_signed ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
  end

  // Wait-state FSM; a dropped request abandons the access and returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op && !dbus.dbus_ack) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!mem_op || dbus.dbus_ack || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM/WB next value: bubble while stalled, otherwise capture with kills.
  always_comb begin
    wb_regwrite_d  = wb_regwrite_q;
    wb_wdsel_d     = wb_wdsel_q;
    wb_gprsel_d    = wb_gprsel_q;
    wb_rd_d        = wb_rd_q;
    wb_aluout_d    = wb_aluout_q;
    wb_pc_d        = wb_pc_q;
    wb_mdata_d     = wb_mdata_q;
    bus_err_d      = 1'b0;
    misalign_err_d = 1'b0;
    if (mem_stall) begin
      wb_regwrite_d = 1'b0;
    end else begin
      wb_regwrite_d = me_RegWrite;
      wb_wdsel_d    = me_WDsel;
      wb_gprsel_d   = me_GPRSel;
      wb_rd_d       = me_rd;
      wb_aluout_d   = me_aluout;
      wb_pc_d       = me_PC;
      wb_mdata_d    = (mem_op && is_load && dbus.dbus_ack) ? ext_data : 32'b0;
      if (timeout) begin
        wb_regwrite_d = 1'b0;
        wb_mdata_d    = 32'b0;
        bus_err_d     = 1'b1;
      end
      if (misalign) begin
        wb_regwrite_d  = 1'b0;
        misalign_err_d = 1'b1;
      end
    end
  end

  // State, counter and MEM/WB registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_wdsel_q     <= 2'b0;
      wb_gprsel_q    <= 2'b0;
      wb_rd_q        <= 5'b0;
      wb_aluout_q    <= 32'b0;
      wb_pc_q        <= 32'b0;
      wb_mdata_q     <= 32'b0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_wdsel_q     <= wb_wdsel_d;
      wb_gprsel_q    <= wb_gprsel_d;
      wb_rd_q        <= wb_rd_d;
      wb_aluout_q    <= wb_aluout_d;
      wb_pc_q        <= wb_pc_d;
      wb_mdata_q     <= wb_mdata_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign wb_RegWrite  = wb_regwrite_q;
  assign wb_WDsel     = wb_wdsel_q;
  assign wb_GPRSel    = wb_gprsel_q;
  assign wb_rd        = wb_rd_q;
  assign wb_aluout    = wb_aluout_q;
  assign wb_PC        = wb_pc_q;
  assign wb_mdata     = wb_mdata_q;
  assign bus_err      = bus_err_q;
  assign misalign_err = misalign_err_q;

endmodule
